// File: rtl/control_unit_if.sv
// Decoder bus: the instruction word in, the registered control vector out.
interface control_unit_if;
    logic [23:0] code;
    logic [1:0]  mux1;
    logic [1:0]  mux5;
    logic [1:0]  mux6;
    logic [2:0]  regs_bank;
    logic        mux4;
    logic        data_mem;
    logic [5:0]  alu;
    logic        comparator;
    logic        write_inst;

    // Fetch side: supplies the instruction word and consumes the controls.
    modport master (
        output code,
        input  mux1, mux5, mux6, regs_bank, mux4, data_mem, alu, comparator, write_inst
    );

    // Decoder side.
    modport slave (
        input  code,
        output mux1, mux5, mux6, regs_bank, mux4, data_mem, alu, comparator, write_inst
    );
endinterface

// File: rtl/control_unit.sv
// Instruction decoder for the 24-bit datapath. Decodes code[23:16] each
// cycle into a registered control vector; operand fields are not looked at.
module control_unit (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);
    logic [1:0] cls_i;
    logic [5:0] fn_i;

    logic [1:0] mux1_d, mux5_d, mux6_d;
    logic [2:0] regs_bank_d;
    logic       mux4_d, data_mem_d, comparator_d, write_inst_d;
    logic [5:0] alu_d;

    logic [1:0] mux1_q, mux5_q, mux6_q;
    logic [2:0] regs_bank_q;
    logic       mux4_q, data_mem_q, comparator_q, write_inst_q;
    logic [5:0] alu_q;

    // Operand fields belong to the datapath; folded here only to mark them as intentionally ignored.
    logic unused_operand;
    assign unused_operand = ^bus.code[15:0];

    assign cls_i = bus.code[23:22];
    assign fn_i  = bus.code[21:16];

    // Combinational decode; anything not matched falls back to the all-zero NOP vector.
    always_comb begin
        mux1_d       = 2'b00;
        mux5_d       = 2'b00;
        mux6_d       = 2'b00;
        regs_bank_d  = 3'b000;
        mux4_d       = 1'b0;
        data_mem_d   = 1'b0;
        alu_d        = 6'b000000;
        comparator_d = 1'b0;
        write_inst_d = 1'b0;
        case (cls_i)
            2'b00: begin
                // Bit 5 of the function selects an immediate operand B, so port B goes unused.
                alu_d       = {1'b0, fn_i[4:0]};
                mux4_d      = fn_i[5];
                regs_bank_d = fn_i[5] ? 3'b101 : 3'b111;
            end
            2'b01: begin
                case (fn_i)
                    6'd0: begin
                        mux4_d      = 1'b1;
                        alu_d       = 6'b001010;
                        mux5_d      = 2'b10;
                        regs_bank_d = 3'b100;
                    end
                    6'd1: begin
                        mux4_d      = 1'b1;
                        alu_d       = 6'b001011;
                        regs_bank_d = 3'b100;
                    end
                    default: ;
                endcase
            end
            2'b10: begin
                case (fn_i)
                    6'd0: begin
                        mux4_d      = 1'b1;
                        mux5_d      = 2'b01;
                        regs_bank_d = 3'b101;
                    end
                    6'd1: begin
                        mux4_d      = 1'b1;
                        regs_bank_d = 3'b011;
                        data_mem_d  = 1'b1;
                    end
                    6'd2: begin
                        mux4_d       = 1'b1;
                        regs_bank_d  = 3'b011;
                        write_inst_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: begin
                case (fn_i)
                    6'd0: mux1_d = 2'b10;
                    6'd1: begin
                        mux1_d      = 2'b10;
                        mux5_d      = 2'b11;
                        mux6_d      = 2'b10;
                        regs_bank_d = 3'b100;
                    end
                    6'd2: begin
                        mux1_d      = 2'b11;
                        regs_bank_d = 3'b001;
                    end
                    6'd3, 6'd4: begin
                        // BNE reuses the BEQ subtract and inverts the compare result.
                        mux1_d       = 2'b01;
                        comparator_d = 1'b1;
                        alu_d        = {fn_i[2], 5'b00001};
                        regs_bank_d  = 3'b011;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // Output register; reset loads the NOP vector and overrides the incoming word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux1_q       <= 2'b00;
            mux5_q       <= 2'b00;
            mux6_q       <= 2'b00;
            regs_bank_q  <= 3'b000;
            mux4_q       <= 1'b0;
            data_mem_q   <= 1'b0;
            alu_q        <= 6'b000000;
            comparator_q <= 1'b0;
            write_inst_q <= 1'b0;
        end else begin
            mux1_q       <= mux1_d;
            mux5_q       <= mux5_d;
            mux6_q       <= mux6_d;
            regs_bank_q  <= regs_bank_d;
            mux4_q       <= mux4_d;
            data_mem_q   <= data_mem_d;
            alu_q        <= alu_d;
            comparator_q <= comparator_d;
            write_inst_q <= write_inst_d;
        end
    end

    assign bus.mux1       = mux1_q;
    assign bus.mux5       = mux5_q;
    assign bus.mux6       = mux6_q;
    assign bus.regs_bank  = regs_bank_q;
    assign bus.mux4       = mux4_q;
    assign bus.data_mem   = data_mem_q;
    assign bus.alu        = alu_q;
    assign bus.comparator = comparator_q;
    assign bus.write_inst = write_inst_q;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected control
// vectors, a monitor pops and compares one per cycle after each edge.
module tb_control_unit;
    logic clk;
    logic rst_n;
    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: mux1, mux5, mux6, regs_bank, mux4, data_mem, alu, comparator, write_inst
    typedef logic [18:0] vec_t;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          started = 1'b0;

    function automatic vec_t pk(input logic [1:0] m1, input logic [1:0] m5, input logic [1:0] m6,
                                input logic [2:0] rb, input logic m4, input logic dm,
                                input logic [5:0] al, input logic cmp, input logic wi);
        return {m1, m5, m6, rb, m4, dm, al, cmp, wi};
    endfunction

    // Reference decode written as a flat opcode table.
    function automatic vec_t ref_dec(input logic [7:0] op);
        vec_t v;
        v = '0;
        if (op[7:6] == 2'b00)
            v = pk(2'b00, 2'b00, 2'b00, op[5] ? 3'b101 : 3'b111, op[5], 1'b0, {1'b0, op[4:0]}, 1'b0, 1'b0);
        else
            case (op)
                8'h40: v = pk(2'b00, 2'b10, 2'b00, 3'b100, 1'b1, 1'b0, 6'b001010, 1'b0, 1'b0);
                8'h41: v = pk(2'b00, 2'b00, 2'b00, 3'b100, 1'b1, 1'b0, 6'b001011, 1'b0, 1'b0);
                8'h80: v = pk(2'b00, 2'b01, 2'b00, 3'b101, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0);
                8'h81: v = pk(2'b00, 2'b00, 2'b00, 3'b011, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
                8'h82: v = pk(2'b00, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1);
                8'hC0: v = pk(2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
                8'hC1: v = pk(2'b10, 2'b11, 2'b10, 3'b100, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
                8'hC2: v = pk(2'b11, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
                8'hC3: v = pk(2'b01, 2'b00, 2'b00, 3'b011, 1'b0, 1'b0, 6'b000001, 1'b1, 1'b0);
                8'hC4: v = pk(2'b01, 2'b00, 2'b00, 3'b011, 1'b0, 1'b0, 6'b100001, 1'b1, 1'b0);
                default: v = '0;
            endcase
        return v;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue what the next rising edge must produce.
    task automatic step(input logic r, input logic [23:0] c, input vec_t e, input string nm);
        @(negedge clk);
        rst_n    = r;
        bus.code = c;
        exp_q.push_back(e);
        name_q.push_back(nm);
        started = 1'b1;
    endtask

    // Monitor: one expected vector per edge, plus the two exclusivity invariants.
    initial begin
        vec_t  act;
        vec_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            act = {bus.mux1, bus.mux5, bus.mux6, bus.regs_bank, bus.mux4, bus.data_mem,
                   bus.alu, bus.comparator, bus.write_inst};
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %b expected %b", nm, act, e);
                end
            end
            if (started) begin
                total++;
                if ((bus.data_mem & bus.write_inst) !== 1'b0) begin
                    bad++;
                    $display("FAIL inv_dm_wi: data_mem=%b write_inst=%b expected not both 1",
                             bus.data_mem, bus.write_inst);
                end
                total++;
                if ((bus.regs_bank[2] & (bus.data_mem | bus.write_inst)) !== 1'b0) begin
                    bad++;
                    $display("FAIL inv_wr_mem: regs_bank=%b data_mem=%b write_inst=%b expected no reg write with mem write",
                             bus.regs_bank, bus.data_mem, bus.write_inst);
                end
            end
        end
    end

    initial begin
        logic [7:0]  op;
        logic [23:0] w;
        logic        r;
        int          waited;
        rst_n    = 1'b0;
        bus.code = 24'hFFFFFF;

        // Reset held with an all-ones word, then release with code=0.
        step(1'b0, 24'hFFFFFF, '0, "reset_1");
        step(1'b0, 24'hFFFFFF, '0, "reset_2");
        step(1'b1, 24'h000000, pk(2'b00, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0), "first_add");

        // Arithmetic with and without immediate operand.
        step(1'b1, 24'h251234, pk(2'b00, 2'b00, 2'b00, 3'b101, 1'b1, 1'b0, 6'b000101, 1'b0, 1'b0), "nor_imm");
        step(1'b1, 24'h09ABCD, pk(2'b00, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0, 6'b001001, 1'b0, 1'b0), "slt_reg");
        step(1'b1, 24'h3F0000, pk(2'b00, 2'b00, 2'b00, 3'b101, 1'b1, 1'b0, 6'b011111, 1'b0, 1'b0), "fn_3f");

        // Constant loads and memory access.
        step(1'b1, 24'h400000, pk(2'b00, 2'b10, 2'b00, 3'b100, 1'b1, 1'b0, 6'b001010, 1'b0, 1'b0), "li");
        step(1'b1, 24'h41FFFF, pk(2'b00, 2'b00, 2'b00, 3'b100, 1'b1, 1'b0, 6'b001011, 1'b0, 1'b0), "lui");
        step(1'b1, 24'h800000, pk(2'b00, 2'b01, 2'b00, 3'b101, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0), "lw");
        step(1'b1, 24'h810000, pk(2'b00, 2'b00, 2'b00, 3'b011, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0), "sw");
        step(1'b1, 24'h820000, pk(2'b00, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1), "swi");

        // Control transfer.
        step(1'b1, 24'hC00000, pk(2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0), "jmp");
        step(1'b1, 24'hC10000, pk(2'b10, 2'b11, 2'b10, 3'b100, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0), "jal");
        step(1'b1, 24'hC20000, pk(2'b11, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0), "jr");
        step(1'b1, 24'hC30000, pk(2'b01, 2'b00, 2'b00, 3'b011, 1'b0, 1'b0, 6'b000001, 1'b1, 1'b0), "beq");
        step(1'b1, 24'hC40000, pk(2'b01, 2'b00, 2'b00, 3'b011, 1'b0, 1'b0, 6'b100001, 1'b1, 1'b0), "bne");

        // Illegal opcodes back-to-back, interleaved with a legal one to expose latency errors.
        step(1'b1, 24'h450000, '0, "illegal_45");
        step(1'b1, 24'hBF0000, '0, "illegal_bf");
        step(1'b1, 24'hC10000, pk(2'b10, 2'b11, 2'b10, 3'b100, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0), "jal_between");
        step(1'b1, 24'hFF0000, '0, "illegal_ff");
        step(1'b1, 24'h830000, '0, "illegal_83");
        step(1'b1, 24'hC50000, '0, "illegal_c5");
        step(1'b1, 24'h420000, '0, "illegal_42");

        // Mid-stream reset discards the pending decode.
        step(1'b1, 24'h810000, pk(2'b00, 2'b00, 2'b00, 3'b011, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0), "sw_pre_reset");
        step(1'b0, 24'hC40000, '0, "reset_mid");
        step(1'b1, 24'hC40000, pk(2'b01, 2'b00, 2'b00, 3'b011, 1'b0, 1'b0, 6'b100001, 1'b1, 1'b0), "bne_post_reset");

        // Undefined operand bits must not disturb the decode.
        step(1'b1, {8'h80, 16'hxxxx}, pk(2'b00, 2'b01, 2'b00, 3'b101, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0), "lw_x_operand");

        // Random words, biased towards the populated opcode space, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            w = 24'($urandom);
            if ($urandom_range(0, 1) == 1) w[21:19] = 3'b000;
            op = w[23:16];
            r  = ($urandom_range(0, 49) != 0);
            step(r, w, r ? ref_dec(op) : '0, "random");
        end

        // Let the monitor drain every queued expectation, bounded.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
